game_sequencer: RTL and testbench

Central controller for the whack-a-mole game: latches the difficulty mode from the push-buttons, then sequences countdown, timed play and result display. Owns the countdown timer, game timer and score counter. Gates the mole generator through `mole_enable_o` and selects the value sent to the BCD/seven-segment display path. Sits between the clock divider / button inputs and the mole, whack and display blocks.

---
 rtl/game_pkg.sv | 25 ++
 rtl/button_edge.sv | 18 +
 rtl/game_sequencer.sv | 121 ++++++++++++
 tb/tb_game_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state/mode encodings and defaults for the game sequencer
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_COUNTDOWN = 2'b01,
      ST_PLAY      = 2'b10,
      ST_DONE      = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      MODE_NONE   = 2'b00,
      MODE_EASY   = 2'b01,
      MODE_MEDIUM = 2'b10,
      MODE_HARD   = 2'b11
   } mode_e;

   localparam int DEFAULT_SCORE_MAX = 9999;

   // A zero-length phase would never see time == 1, so it is stretched to one second.
   function automatic logic [7:0] load_secs(input int secs);
      return (secs <= 0) ? 8'd1 : 8'(secs);
   endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - 4-bit rising-edge detector for the debounced push-buttons
module button_edge (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [3:0] buttons_i,
   output logic [3:0] rise_o
);

   logic [3:0] prev_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) prev_q <= '0;
      else          prev_q <= buttons_i;
   end

   assign rise_o = buttons_i & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - mode latch, countdown/play timers, score and display select
module game_sequencer
   import game_pkg::*;
#(
   parameter int COUNTDOWN_S = 3,
   parameter int GAME_S      = 30,
   parameter int SCORE_MAX   = DEFAULT_SCORE_MAX
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        tick_1hz_i,
   input  logic [3:0]  buttons_i,
   input  logic        whacked_i,
   output logic [1:0]  mode_o,
   output logic [1:0]  state_o,
   output logic        mole_enable_o,
   output logic [7:0]  time_o,
   output logic [15:0] score_o,
   output logic [15:0] display_o,
   output logic        game_done_o
);

   localparam logic [7:0]  CD_LOAD   = load_secs(COUNTDOWN_S);
   localparam logic [7:0]  GAME_LOAD = load_secs(GAME_S);
   localparam logic [15:0] SCORE_CAP = 16'(SCORE_MAX);

   state_e      state_q, state_d;
   mode_e       mode_q, mode_d;
   logic [7:0]  time_q, time_d;
   logic [15:0] score_q, score_d;
   logic [15:0] display_q, display_d;
   logic        mole_q, done_q;
   logic [3:0]  rise;

   button_edge u_button_edge (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .buttons_i (buttons_i),
      .rise_o    (rise)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      time_d    = time_q;
      score_d   = score_q;
      display_d = '0;
      case (state_q)
         ST_IDLE: begin
            if      (rise[0]) mode_d = MODE_EASY;
            else if (rise[1]) mode_d = MODE_MEDIUM;
            else if (rise[2]) mode_d = MODE_HARD;
            // Start qualifies on the mode already latched, not one arriving this cycle.
            if (rise[3] && mode_q != MODE_NONE) begin
               state_d = ST_COUNTDOWN;
               time_d  = CD_LOAD;
               score_d = '0;
            end
         end
         ST_COUNTDOWN: begin
            if (tick_1hz_i) begin
               if (time_q <= 8'd1) begin
                  state_d = ST_PLAY;
                  time_d  = GAME_LOAD;
               end else begin
                  time_d = time_q - 8'd1;
               end
            end
         end
         ST_PLAY: begin
            if (whacked_i && score_q < SCORE_CAP) score_d = score_q + 16'd1;
            if (tick_1hz_i) begin
               if (time_q <= 8'd1) begin
                  state_d = ST_DONE;
                  time_d  = 8'd0;
               end else begin
                  time_d = time_q - 8'd1;
               end
            end
         end
         default: begin
            if (rise[3]) state_d = ST_IDLE;
         end
      endcase
      // Display follows the next state so it lines up with the registered state.
      case (state_d)
         ST_IDLE: display_d = {14'd0, mode_d};
         ST_DONE: display_d = score_d;
         default: display_d = {8'd0, time_d};
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_NONE;
         time_q    <= '0;
         score_q   <= '0;
         display_q <= '0;
         mole_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         time_q    <= time_d;
         score_q   <= score_d;
         display_q <= display_d;
         mole_q    <= (state_d == ST_PLAY);
         done_q    <= (state_q == ST_PLAY) && (state_d == ST_DONE);
      end
   end

   assign state_o       = state_q;
   assign mode_o        = mode_q;
   assign time_o        = time_q;
   assign score_o       = score_q;
   assign display_o     = display_q;
   assign mole_enable_o = mole_q;
   assign game_done_o   = done_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
module tb_game_sequencer;

   typedef struct packed {
      logic [1:0]  st;
      logic [1:0]  mode;
      logic [7:0]  tim;
      logic [15:0] score;
      logic [15:0] disp;
      logic        mole;
      logic        done;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_1hz = 1'b0;
   logic [3:0]  buttons = 4'd0;
   logic        whacked = 1'b0;

   logic [1:0]  mode_o, state_o, sat_mode, sat_state;
   logic        mole_enable_o, game_done_o, sat_mole, sat_done;
   logic [7:0]  time_o, sat_time;
   logic [15:0] score_o, display_o, sat_score, sat_display;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [1:0]  m_st, m_mode;
   logic [7:0]  m_time;
   logic [15:0] m_score;
   logic [3:0]  m_prev;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clock_i(clk), .reset_i(rst_n), .tick_1hz_i(tick_1hz), .buttons_i(buttons),
      .whacked_i(whacked), .mode_o(mode_o), .state_o(state_o), .mole_enable_o(mole_enable_o),
      .time_o(time_o), .score_o(score_o), .display_o(display_o), .game_done_o(game_done_o)
   );

   game_sequencer #(.SCORE_MAX(3)) dut_sat (
      .clock_i(clk), .reset_i(rst_n), .tick_1hz_i(tick_1hz), .buttons_i(buttons),
      .whacked_i(whacked), .mode_o(sat_mode), .state_o(sat_state), .mole_enable_o(sat_mole),
      .time_o(sat_time), .score_o(sat_score), .display_o(sat_display), .game_done_o(sat_done)
   );

   function automatic obs_t observe();
      obs_t o;
      o.st = state_o; o.mode = mode_o; o.tim = time_o; o.score = score_o;
      o.disp = display_o; o.mole = mole_enable_o; o.done = game_done_o;
      return o;
   endfunction

   task automatic model_reset();
      m_st = 2'b00; m_mode = 2'b00; m_time = 8'd0; m_score = 16'd0; m_prev = 4'd0;
      exp_q.push_back('0);
   endtask

   task automatic model_step(input logic tick, input logic whack, input logic [3:0] btn);
      logic [3:0] rise;
      logic [1:0] old_mode;
      logic       done;
      obs_t       e;
      rise = btn & ~m_prev;
      m_prev = btn;
      old_mode = m_mode;
      done = 1'b0;
      case (m_st)
         2'b00: begin
            if (rise[0]) m_mode = 2'b01;
            else if (rise[1]) m_mode = 2'b10;
            else if (rise[2]) m_mode = 2'b11;
            if (rise[3] && old_mode != 2'b00) begin
               m_st = 2'b01; m_time = 8'd3; m_score = 16'd0;
            end
         end
         2'b01: if (tick) begin
            if (m_time == 8'd1) begin m_st = 2'b10; m_time = 8'd30; end
            else m_time = m_time - 8'd1;
         end
         2'b10: begin
            if (whack && m_score < 16'd9999) m_score = m_score + 16'd1;
            if (tick) begin
               if (m_time == 8'd1) begin m_st = 2'b11; m_time = 8'd0; done = 1'b1; end
               else m_time = m_time - 8'd1;
            end
         end
         default: if (rise[3]) m_st = 2'b00;
      endcase
      e.st = m_st; e.mode = m_mode; e.tim = m_time; e.score = m_score;
      e.mole = (m_st == 2'b10); e.done = done;
      e.disp = (m_st == 2'b00) ? {14'd0, m_mode} : (m_st == 2'b11) ? m_score : {8'd0, m_time};
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic tick, input logic whack, input logic [3:0] btn);
      tick_1hz = tick; whacked = whack; buttons = btn;
      model_step(tick, whack, btn);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      obs_t got, want;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_values got %h want %h", got, want); end
      rst_n = 1'b1;
      drive(0, 0, 4'd0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_release got %h want %h", got, want); end
   endtask

   task automatic test_mode_latch();
      obs_t got, want;
      logic [3:0] pat [6] = '{4'b1000, 4'b0000, 4'b0101, 4'b0000, 4'b0010, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, pat[i]);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL mode_step%0d got %h want %h", i, got, want); end
         if (i == 2) begin
            checks++;
            if (mode_o !== 2'b01) begin errors++; $display("FAIL mode_lowest_wins got %b want 01", mode_o); end
         end
      end
   endtask

   task automatic test_countdown();
      obs_t got, want;
      drive(0, 0, 4'b1000);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL cd_start got %h want %h", got, want); end
      drive(0, 0, 4'b0000);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL cd_release got %h want %h", got, want); end
      for (int i = 0; i < 3; i++) begin
         drive(1, i == 2, 4'd0);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL cd_tick%0d got %h want %h", i, got, want); end
         drive(0, i < 2, 4'd0);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL cd_gap%0d got %h want %h", i, got, want); end
      end
      checks++;
      if (state_o !== 2'b10 || time_o !== 8'd30 || mode_o !== 2'b10 || mole_enable_o !== 1'b1 || score_o !== 16'd0) begin
         errors++;
         $display("FAIL cd_enter_play got st=%b t=%0d m=%b mole=%b sc=%0d want st=10 t=30 m=10 mole=1 sc=0",
                  state_o, time_o, mode_o, mole_enable_o, score_o);
      end
   endtask

   task automatic test_play_done();
      obs_t got, want;
      int   done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 4'd0);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL play_whack%0d got %h want %h", i, got, want); end
      end
      checks++;
      if (sat_score !== 16'd3) begin errors++; $display("FAIL score_saturate got %0d want 3", sat_score); end
      for (int i = 0; i < 30; i++) begin
         drive(1, 0, 4'd0);
         done_cnt += int'(game_done_o);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL play_tick%0d got %h want %h", i, got, want); end
      end
      drive(0, 1, 4'd0);
      done_cnt += int'(game_done_o);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL done_whack got %h want %h", got, want); end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL done_pulse_count got %0d want 1", done_cnt); end
      checks++;
      if (score_o !== 16'd5 || display_o !== 16'd5 || mole_enable_o !== 1'b0) begin
         errors++;
         $display("FAIL done_outputs got sc=%0d disp=%0d mole=%b want sc=5 disp=5 mole=0", score_o, display_o, mole_enable_o);
      end
   endtask

   task automatic test_final_tick_whack();
      obs_t got, want;
      logic [3:0] pre [4] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, pre[i]);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL b2b_restart%0d got %h want %h", i, got, want); end
      end
      for (int i = 0; i < 32; i++) begin
         drive(1, 0, 4'd0);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL b2b_tick%0d got %h want %h", i, got, want); end
      end
      drive(1, 1, 4'd0);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL final_tick_whack got %h want %h", got, want); end
      checks++;
      if (state_o !== 2'b11 || score_o !== 16'd1 || game_done_o !== 1'b1) begin
         errors++;
         $display("FAIL final_tick_outputs got st=%b sc=%0d done=%b want st=11 sc=1 done=1", state_o, score_o, game_done_o);
      end
   endtask

   task automatic test_reset_mid_play();
      obs_t got, want;
      logic [3:0] pre [4] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
      logic [3:0] post [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b0000, 4'b1000};
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, pre[i]);
         void'(exp_q.pop_front());
      end
      for (int i = 0; i < 3; i++) begin drive(1, 0, 4'd0); void'(exp_q.pop_front()); end
      for (int i = 0; i < 7; i++) begin drive(0, 1, 4'd0); void'(exp_q.pop_front()); end
      for (int i = 0; i < 18; i++) begin drive(1, 0, 4'd0); void'(exp_q.pop_front()); end
      checks++;
      if (state_o !== 2'b10 || time_o !== 8'd12 || score_o !== 16'd7) begin
         errors++;
         $display("FAIL midplay_setup got st=%b t=%0d sc=%0d want st=10 t=12 sc=7", state_o, time_o, score_o);
      end
      #2;
      rst_n = 1'b0;
      buttons = 4'b1000;
      model_reset();
      #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL async_reset got %h want %h", got, want); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, post[i]);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL post_reset%0d got %h want %h", i, got, want); end
      end
   endtask

   initial begin
      test_reset();
      test_mode_latch();
      test_countdown();
      test_play_done();
      test_final_tick_whack();
      test_reset_mid_play();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
